ball_collision_unit: RTL

- Upstream stage of the ball FSM. Each clock it compares the ball box (ball_x, ball_y, ball_size_x, ball_size_y) against the screen walls, both paddles and both goal lines.
- Produces the 2-bit bounce code the ball FSM consumes: 00 none, 01 paddle, 10 wall, 11 scored/re-serve.
- Keeps per-player scores and a sticky game_over flag.
- Sits between the ball FSM and the paddle modules in the game-logic top.

---
 rtl/game_pkg.sv | 26 ++
 rtl/box_overlap.sv | 21 ++
 rtl/ball_collision_unit.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared game-logic definitions: bounce encoding, collision FSM states, screen defaults.
package game_pkg;

  localparam int unsigned COORD_W = 10;
  localparam int unsigned EDGE_W  = 11;
  localparam int unsigned SIZE_W  = 8;
  localparam int unsigned SCORE_W = 4;
  localparam int unsigned CNT_W   = 8;

  localparam int unsigned SCREEN_X_DEF = 640;
  localparam int unsigned SCREEN_Y_DEF = 480;

  // Bounce codes as decoded by the ball FSM
  localparam logic [1:0] BOUNCE_NONE   = 2'b00;
  localparam logic [1:0] BOUNCE_PADDLE = 2'b01;
  localparam logic [1:0] BOUNCE_WALL   = 2'b10;
  localparam logic [1:0] BOUNCE_SCORE  = 2'b11;

  typedef enum logic [1:0] {
    PLAY  = 2'd0,
    HOLD  = 2'd1,
    SERVE = 2'd2,
    OVER  = 2'd3
  } state_t;

endpackage

// File: rtl/box_overlap.sv
// Axis-aligned box overlap test; boxes are half-open [lo, hi) on both axes.
module box_overlap
  import game_pkg::*;
(
  input  logic [EDGE_W-1:0] a_x1,
  input  logic [EDGE_W-1:0] a_x2,
  input  logic [EDGE_W-1:0] a_y1,
  input  logic [EDGE_W-1:0] a_y2,
  input  logic [EDGE_W-1:0] b_x1,
  input  logic [EDGE_W-1:0] b_x2,
  input  logic [EDGE_W-1:0] b_y1,
  input  logic [EDGE_W-1:0] b_y2,
  output logic              hit_c
);

  // Overlap on both axes at once
  always_comb begin
    hit_c = (a_x1 < b_x2) && (a_x2 > b_x1) && (a_y1 < b_y2) && (a_y2 > b_y1);
  end

endmodule

// File: rtl/ball_collision_unit.sv
// Ball collision detection, bounce code generation and score keeping.
module ball_collision_unit
  import game_pkg::*;
#(
  parameter int unsigned SCREEN_X     = SCREEN_X_DEF,
  parameter int unsigned SCREEN_Y     = SCREEN_Y_DEF,
  parameter int unsigned PADDLE_L_X   = 16,
  parameter int unsigned PADDLE_R_X   = 608,
  parameter int unsigned PADDLE_W     = 16,
  parameter int unsigned PADDLE_H     = 80,
  parameter int unsigned HOLD_CYCLES  = 8,
  parameter int unsigned SERVE_CYCLES = 64,
  parameter int unsigned WIN_SCORE    = 9
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [COORD_W-1:0]   ball_x,
  input  logic [COORD_W-1:0]   ball_y,
  input  logic [SIZE_W-1:0]    ball_size_x,
  input  logic [SIZE_W-1:0]    ball_size_y,
  input  logic [COORD_W-1:0]   paddle_l_y,
  input  logic [COORD_W-1:0]   paddle_r_y,
  output logic [1:0]           bounce,
  output logic [SCORE_W-1:0]   score_l,
  output logic [SCORE_W-1:0]   score_r,
  output logic                 game_over
);

  localparam logic [EDGE_W-1:0] PAD_L_X1 = EDGE_W'(PADDLE_L_X);
  localparam logic [EDGE_W-1:0] PAD_L_X2 = EDGE_W'(PADDLE_L_X + PADDLE_W);
  localparam logic [EDGE_W-1:0] PAD_R_X1 = EDGE_W'(PADDLE_R_X);
  localparam logic [EDGE_W-1:0] PAD_R_X2 = EDGE_W'(PADDLE_R_X + PADDLE_W);

  state_t               state, state_next;
  logic [CNT_W-1:0]     cnt, cnt_next;
  logic [1:0]           bounce_next;
  logic [SCORE_W-1:0]   score_l_next, score_r_next;
  logic                 game_over_next;

  logic [EDGE_W-1:0]    bx1, bx2, by1, by2;
  logic [EDGE_W-1:0]    pl_y1, pl_y2, pr_y1, pr_y2;
  logic                 goal_l, goal_r, goal_any, wall, pad_l, pad_r;
  logic                 live, win;

  // Ball and paddle box edges, widened so nothing wraps
  always_comb begin
    bx1   = EDGE_W'(ball_x);
    by1   = EDGE_W'(ball_y);
    bx2   = EDGE_W'(ball_x) + EDGE_W'(ball_size_x);
    by2   = EDGE_W'(ball_y) + EDGE_W'(ball_size_y);
    pl_y1 = EDGE_W'(paddle_l_y);
    pl_y2 = EDGE_W'(paddle_l_y) + EDGE_W'(PADDLE_H);
    pr_y1 = EDGE_W'(paddle_r_y);
    pr_y2 = EDGE_W'(paddle_r_y) + EDGE_W'(PADDLE_H);
  end

  box_overlap u_pad_l (
    .a_x1(bx1), .a_x2(bx2), .a_y1(by1), .a_y2(by2),
    .b_x1(PAD_L_X1), .b_x2(PAD_L_X2), .b_y1(pl_y1), .b_y2(pl_y2),
    .hit_c(pad_l)
  );

  box_overlap u_pad_r (
    .a_x1(bx1), .a_x2(bx2), .a_y1(by1), .a_y2(by2),
    .b_x1(PAD_R_X1), .b_x2(PAD_R_X2), .b_y1(pr_y1), .b_y2(pr_y2),
    .hit_c(pad_r)
  );

  // Goal/wall flags; a goal on the left side masks a simultaneous right goal
  always_comb begin
    goal_l   = (ball_x == '0);
    goal_r   = !goal_l && (bx2 >= EDGE_W'(SCREEN_X));
    goal_any = goal_l || goal_r;
    wall     = (ball_y == '0) || (by2 >= EDGE_W'(SCREEN_Y));
    live     = (state == PLAY) || (state == HOLD);
    win      = goal_l ? (score_r == SCORE_W'(WIN_SCORE - 1))
                      : (score_l == SCORE_W'(WIN_SCORE - 1));
  end

  // State, counter and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= PLAY;
      cnt       <= '0;
      bounce    <= BOUNCE_NONE;
      score_l   <= '0;
      score_r   <= '0;
      game_over <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      bounce    <= bounce_next;
      score_l   <= score_l_next;
      score_r   <= score_r_next;
      game_over <= game_over_next;
    end
  end

  // Next state and cooldown counter
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      PLAY, HOLD: begin
        if (goal_any) begin
          state_next = win ? OVER : SERVE;
          cnt_next   = CNT_W'(SERVE_CYCLES);
        end else if (state == PLAY) begin
          if (pad_l || pad_r || wall) begin
            state_next = HOLD;
            cnt_next   = CNT_W'(HOLD_CYCLES);
          end
        end else if (cnt <= CNT_W'(1)) begin
          state_next = PLAY;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      SERVE: begin
        if (cnt <= CNT_W'(1)) begin
          state_next = PLAY;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      OVER:    state_next = OVER;
      default: state_next = PLAY;
    endcase
  end

  // Bounce pulse, score increments and game-over flag
  always_comb begin
    bounce_next    = BOUNCE_NONE;
    score_l_next   = score_l;
    score_r_next   = score_r;
    game_over_next = game_over;
    if (live && goal_any) begin
      bounce_next = BOUNCE_SCORE;
      if (goal_l) begin
        if (score_r < SCORE_W'(WIN_SCORE)) score_r_next = score_r + SCORE_W'(1);
      end else begin
        if (score_l < SCORE_W'(WIN_SCORE)) score_l_next = score_l + SCORE_W'(1);
      end
      if (win) game_over_next = 1'b1;
    end else if (state == PLAY) begin
      if (pad_l || pad_r) bounce_next = BOUNCE_PADDLE;
      else if (wall)      bounce_next = BOUNCE_WALL;
    end
  end

endmodule
